regfile_scoreboard: RTL

Parametrised integer register file for the pipelined core, with a per-register pending-write scoreboard that produces the ID-stage stall. It replaces a plain two-read, one-write register file and the separate load-use hazard check. It sits in ID: decode reads operands from it and issues destination reservations to it, and WB retires writes into it.

---
 rtl/regfile_scoreboard.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
//
// Integer register file for the ID stage with a per-register pending-write
// scoreboard. Decode reads its operands here and reserves its destination
// register. WB retires writes into the same block. The block produces the
// ID-stage stall for load-use and other read-after-write hazards.
//
// Register 0 is hardwired to zero. Each of registers 1..NREG-1 has a CNTW-bit
// counter of writes that are in flight. A reader whose register has a
// non-zero count stalls. An issue whose destination counter is saturated
// also stalls.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - a same-cycle WB write is forwarded to the matching read port.
//               The last outstanding write also waives that port's stall in
//               the write cycle itself.
//   undefined - reads return stored contents only. Readers resume the cycle
//               after the write.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   rd_addr_i      NRD packed read addresses, port k = [k*AW +: AW]
//   rd_use_i       per-port "operand consumed" flag, gates the stall check
//   rd_data_o      NRD packed read data, combinational
//   issue_valid_i  ID instruction requests issue
//   issue_wr_i     issuing instruction writes a destination
//   issue_rd_i     destination of the issuing instruction
//   stall_o        issue refused this cycle
//   wr_en_i        WB write strobe
//   wr_addr_i      WB destination
//   wr_data_i      WB data
//   busy_o         some pending counter is non-zero (registered state)
//   err_o          sticky: a write retired to a register with nothing pending
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int CNTW = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    input  logic [NRD-1:0]      rd_use_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic                issue_valid_i,
    input  logic                issue_wr_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic                stall_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    // Address 0 and addresses beyond NREG have no storage and no counter.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREG);
    endfunction

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [CNTW-1:0] cnt_q  [1:NREG-1];
    logic [CNTW-1:0] cnt_d  [1:NREG-1];
    logic            err_q, err_d;

    logic write_ok;
    logic accept;

    assign write_ok = wr_en_i && addr_ok(wr_addr_i);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        logic [AW-1:0] addr;
        // NOTE: each variable written here gets a default before any
        // conditional assignment. Otherwise a path that skips the assignment
        // would infer a latch.
        rd_data_o = '0;
        addr      = '0;
        for (int k = 0; k < NRD; k++) begin
            addr = rd_addr_i[k*AW +: AW];
            if (addr_ok(addr)) begin
                rd_data_o[k*XLEN +: XLEN] = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
                if (write_ok && (wr_addr_i == addr)) begin
                    rd_data_o[k*XLEN +: XLEN] = wr_data_i;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall and issue acceptance
    // ------------------------------------------------------------------
    always_comb begin
        logic [AW-1:0] addr;
        logic          conflict;
        logic          saturate;
        addr     = '0;
        conflict = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            addr = rd_addr_i[k*AW +: AW];
            if (rd_use_i[k] && addr_ok(addr) && (cnt_q[addr] != '0)) begin
`ifdef REGFILE_BYPASS_EN
                // The retiring write is the last one outstanding. Its data
                // is forwarded this cycle, so the reader can proceed.
                if (!((cnt_q[addr] == CNT_ONE) && write_ok && (wr_addr_i == addr))) begin
                    conflict = 1'b1;
                end
`else
                conflict = 1'b1;
`endif
            end
        end
        // Saturation looks only at the stored count. A same-cycle
        // retirement does not free a slot until the next cycle.
        saturate = issue_wr_i && addr_ok(issue_rd_i) && (cnt_q[issue_rd_i] == CNT_MAX);
        stall_o  = issue_valid_i && (conflict || saturate);
        accept   = issue_valid_i && !stall_o && issue_wr_i && addr_ok(issue_rd_i);
    end

    // ------------------------------------------------------------------
    // Next state: storage, counters, error flag
    // ------------------------------------------------------------------
    always_comb begin
        logic inc, dec;
        regs_d = regs_q;
        cnt_d  = cnt_q;
        inc    = 1'b0;
        dec    = 1'b0;

        if (write_ok) begin
            regs_d[wr_addr_i] = wr_data_i;
        end

        for (int r = 1; r < NREG; r++) begin
            inc = accept   && (issue_rd_i == AW'(r));
            dec = write_ok && (wr_addr_i  == AW'(r));
            // An accept and a write to the same register cancel out.
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end

        // The write is still performed. The count saturates at 0.
        err_d = err_q ||
                (write_ok && (cnt_q[wr_addr_i] == '0) &&
                 !(accept && (issue_rd_i == wr_addr_i)));
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the register array is reset explicitly. The architecture
            // requires every register to read 0 after reset, so this storage
            // cannot be left uninitialised like a RAM.
            regs_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy_o = busy_o || (cnt_q[r] != '0);
        end
    end

    assign err_o = err_q;

endmodule
